// File: rtl/cordic_pkg.sv
// Shared constants and encodings for the CORDIC sequencer, datapath and display mux.
package cordic_pkg;

    localparam int unsigned ITER_DEF  = 14;
    localparam int unsigned IW_DEF    = 4;
    localparam int unsigned NFUNC_DEF = 9;
    localparam int unsigned DW        = 16;

    localparam logic [DW-1:0] Q_ONE = 16'h4000;

    // Bit n set means function code n consumes both operands.
    localparam logic [8:0] TWO_OP_MASK = 9'b0_1000_0011;

    localparam logic [3:0] F_0 = 4'd0;
    localparam logic [3:0] F_1 = 4'd1;
    localparam logic [3:0] F_2 = 4'd2;
    localparam logic [3:0] F_3 = 4'd3;
    localparam logic [3:0] F_4 = 4'd4;
    localparam logic [3:0] F_5 = 4'd5;
    localparam logic [3:0] F_6 = 4'd6;
    localparam logic [3:0] F_7 = 4'd7;
    localparam logic [3:0] F_8 = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FUNC = 3'd1,
        S_OP1  = 3'd2,
        S_OP2  = 3'd3,
        S_ARM  = 3'd4,
        S_LOAD = 3'd5,
        S_RUN  = 3'd6,
        S_DONE = 3'd7
    } state_e;

    function automatic logic is_two_op(input logic [3:0] code);
        logic [15:0] mask;
        mask = 16'(TWO_OP_MASK);
        return mask[code];
    endfunction

endpackage

// File: rtl/cordic_iter_cnt.sv
// Micro-rotation index counter: clear, load, increment, and a registered
// terminal-count flag that is high while the count equals ITER-1.
module cordic_iter_cnt #(
    parameter int unsigned ITER = 14,
    parameter int unsigned IW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          ld_i,
    input  logic [IW-1:0] ld_val_i,
    input  logic          en_i,
    output logic [IW-1:0] cnt_o,
    output logic          tc_o
);

    logic [IW-1:0] cnt_q, cnt_d;
    logic          tc_q, tc_d;

    // Clear wins over load, load over increment; the count wraps to 0 after ITER-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            cnt_d = tc_q ? '0 : IW'(cnt_q + 1'b1);
        end
        tc_d = (cnt_d == IW'(ITER - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'(ITER == 1);
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = tc_q;

endmodule

// File: rtl/cordic_seq.sv
// Operand-entry and iteration sequencer: collects function and operands via
// st pulses, then loads and steps the CORDIC datapath for ITER rotations.
module cordic_seq
    import cordic_pkg::*;
#(
    parameter int unsigned   ITER  = ITER_DEF,
    parameter int unsigned   IW    = IW_DEF,
    parameter int unsigned   NFUNC = NFUNC_DEF,
    parameter logic [15:0]   ONE   = Q_ONE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st,
    input  logic [15:0]   sw_in,
    output logic [3:0]    dp_func,
    output logic [15:0]   dp_op1,
    output logic [15:0]   dp_op2,
    output logic          dp_load,
    output logic          dp_step,
    output logic [IW-1:0] dp_iter,
    output logic [2:0]    phase,
    output logic          busy,
    output logic          result_valid,
    output logic          err
);

    state_e        state_q, state_d;
    logic [3:0]    func_q, func_d;
    logic [15:0]   op1_q, op1_d;
    logic [15:0]   op2_q, op2_d;
    logic          load_q, load_d;
    logic          step_q, step_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          cnt_clr, cnt_en, cnt_tc;
    logic [IW-1:0] cnt_val;

    cordic_iter_cnt #(
        .ITER (ITER),
        .IW   (IW)
    ) u_iter_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (cnt_clr),
        .ld_i     (1'b0),
        .ld_val_i ('0),
        .en_i     (cnt_en),
        .cnt_o    (cnt_val),
        .tc_o     (cnt_tc)
    );

    // Next state, operand latches, and counter control.
    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        err_d   = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (st) state_d = S_FUNC;
            end
            S_FUNC: begin
                if (st) begin
                    if (32'(sw_in[3:0]) >= NFUNC) begin
                        err_d = 1'b1;
                    end else begin
                        func_d = sw_in[3:0];
                        if (is_two_op(sw_in[3:0])) begin
                            state_d = S_OP1;
                        end else begin
                            op1_d   = ONE;
                            state_d = S_OP2;
                        end
                    end
                end
            end
            S_OP1: begin
                if (st) begin
                    op1_d   = sw_in;
                    state_d = S_OP2;
                end
            end
            S_OP2: begin
                if (st) begin
                    op2_d   = sw_in;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (st) begin
                    cnt_clr = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_en = 1'b1;
                if (cnt_tc) state_d = S_DONE;
            end
            S_DONE: begin
                if (st) state_d = S_FUNC;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they line up with phase.
    always_comb begin
        load_d  = (state_d == S_LOAD);
        step_d  = (state_d == S_RUN);
        busy_d  = (state_d == S_LOAD) || (state_d == S_RUN);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            func_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            load_q  <= 1'b0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            load_q  <= load_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign dp_func      = func_q;
    assign dp_op1       = op1_q;
    assign dp_op2       = op2_q;
    assign dp_load      = load_q;
    assign dp_step      = step_q;
    assign dp_iter      = cnt_val;
    assign phase        = state_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_cordic_seq.sv
// Scoreboard bench for cordic_seq: stimulus pushes expected results, a monitor
// checks each completed run (latched operands, step count, index sequence).
module tb_cordic_seq;

    localparam int          ITER = 14;
    localparam logic [15:0] ONE  = 16'h4000;

    logic        clk;
    logic        rst;
    logic        st;
    logic [15:0] sw_in;
    logic [3:0]  dp_func;
    logic [15:0] dp_op1;
    logic [15:0] dp_op2;
    logic        dp_load;
    logic        dp_step;
    logic [3:0]  dp_iter;
    logic [2:0]  phase;
    logic        busy;
    logic        result_valid;
    logic        err;

    cordic_seq dut (
        .clk          (clk),
        .rst          (rst),
        .st           (st),
        .sw_in        (sw_in),
        .dp_func      (dp_func),
        .dp_op1       (dp_op1),
        .dp_op2       (dp_op2),
        .dp_load      (dp_load),
        .dp_step      (dp_step),
        .dp_iter      (dp_iter),
        .phase        (phase),
        .busy         (busy),
        .result_valid (result_valid),
        .err          (err)
    );

    typedef struct {
        logic [3:0]  f;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rule: codes 0, 1 and 7 take two operands; others use 1.0 for op1.
    function automatic bit model_two_op(input int f);
        return (f == 0) || (f == 1) || (f == 7);
    endfunction

    // Called and returns at a falling edge; st is seen by exactly one rising edge.
    task automatic pulse_st(input logic [15:0] v);
        sw_in = v;
        st    = 1'b1;
        @(negedge clk);
        st    = 1'b0;
    endtask

    task automatic to_func();
        pulse_st(16'h0000);
        chk("to_func_phase", 32'(phase), 32'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!result_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("done_phase", 32'(phase), 32'd7);
        chk("done_valid", 32'(result_valid), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    task automatic wait_iter(input logic [3:0] v);
        int n;
        n = 0;
        while (dp_iter !== v && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("iter_reached", 32'(dp_iter), 32'(v));
    endtask

    task automatic enter_ops(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        pulse_st(16'(f));
        if (model_two_op(int'(f))) begin
            chk("phase_op1", 32'(phase), 32'd2);
            pulse_st(a);
        end else begin
            chk("phase_op2_direct", 32'(phase), 32'd3);
            chk("op1_one", 32'(dp_op1), 32'(ONE));
        end
        pulse_st(b);
        chk("phase_arm", 32'(phase), 32'd4);
    endtask

    task automatic run_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   n;
        e.f = f;
        e.a = model_two_op(int'(f)) ? a : ONE;
        e.b = b;
        enter_ops(f, a, b);
        sb.push_back(e);
        pulse_st(16'h0000);
        chk("load_pulse", 32'(dp_load), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("latency", 32'(n), 32'(ITER + 1));
    endtask

    // Monitor: tracks each run from dp_load to the rise of result_valid.
    initial begin : monitor
        bit   in_run;
        bit   prev_rv;
        bit   iter_bad;
        int   steps;
        int   loads;
        exp_t e;
        in_run = 0; prev_rv = 0; iter_bad = 0; steps = 0; loads = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                in_run = 0; prev_rv = 0; steps = 0; loads = 0; iter_bad = 0;
            end else begin
                if (dp_load) begin
                    loads++;
                    if (!in_run) begin
                        in_run = 1; steps = 0; iter_bad = 0;
                    end
                end
                if (dp_step) begin
                    if (!in_run || int'(dp_iter) != steps) iter_bad = 1;
                    steps++;
                end
                if (result_valid && !prev_rv) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: result with no expected entry (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_func", 32'(dp_func), 32'(e.f));
                        chk("sb_op1", 32'(dp_op1), 32'(e.a));
                        chk("sb_op2", 32'(dp_op2), 32'(e.b));
                        chk("sb_steps", 32'(steps), 32'(ITER));
                        chk("sb_loads", 32'(loads), 32'd1);
                        chk("sb_iter_seq", 32'(iter_bad), 32'd0);
                    end
                    in_run = 0; loads = 0; steps = 0;
                end
                prev_rv = result_valid;
            end
        end
    end

    initial begin : stim
        int n;
        rst   = 1'b1;
        st    = 1'b0;
        sw_in = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_outs", {dp_load, dp_step, busy, result_valid, err}, 32'd0);
        chk("rst_regs", {12'(dp_func), dp_op1 | dp_op2, 4'(dp_iter)}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-operand path.
        to_func();
        run_op(4'd1, 16'h4000, 16'h2A9B);

        // One-operand path over a stale op1.
        to_func();
        run_op(4'd0, 16'h1234, 16'h1111);
        to_func();
        run_op(4'd3, 16'hFFFF, 16'h6488);

        // Illegal code pulses err only.
        to_func();
        pulse_st(16'h0009);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_phase", 32'(phase), 32'd1);
        chk("err_func_kept", 32'(dp_func), 32'd3);
        @(negedge clk);
        chk("err_one_cycle", 32'(err), 32'd0);
        pulse_st(16'hABCF);
        chk("err_pulse_f", 32'(err), 32'd1);
        chk("err_phase_f", 32'(phase), 32'd1);
        run_op(4'd7, 16'h0101, 16'h2020);

        // st during LOAD and RUN is ignored.
        to_func();
        begin
            exp_t e;
            e.f = 4'd1; e.a = 16'h3333; e.b = 16'h4444;
            enter_ops(4'd1, 16'h3333, 16'h4444);
            sb.push_back(e);
            pulse_st(16'h0000);
            chk("ign_load_pulse", 32'(dp_load), 32'd1);
            pulse_st(16'h0005);
            wait_iter(4'd3);
            pulse_st(16'h0002);
            wait_iter(4'd13);
            pulse_st(16'h0007);
            wait_done(n);
            to_func();
        end

        // Back-to-back: every legal code with eight random operand pairs.
        for (int f = 0; f < 9; f++) begin
            for (int p = 0; p < 8; p++) begin
                run_op(4'(f), 16'($urandom), 16'($urandom));
                to_func();
            end
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Reset in the middle of a run.
        enter_ops(4'd1, 16'h5555, 16'h6666);
        pulse_st(16'h0000);
        wait_iter(4'd5);
        chk("pre_rst_step", 32'(dp_step), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_phase", 32'(phase), 32'd0);
        chk("midrun_rst_step", 32'(dp_step), 32'd0);
        chk("midrun_rst_iter", 32'(dp_iter), 32'd0);
        chk("midrun_rst_valid", 32'(result_valid), 32'd0);
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_ops", {dp_op1, dp_op2}, 32'd0);
        chk("midrun_rst_func", 32'(dp_func), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(phase), 32'd0);
        chk("post_rst_valid", 32'(result_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
